// File: rtl/sccomp_dbg_pkg.sv
// Shared definitions for the single-cycle MIPS run/readback controller:
// FSM encoding, stop-cause codes and the default debug-port widths.
package sccomp_dbg_pkg;

    localparam int DBG_DATA_W   = 32;
    localparam int DBG_ADDR_W   = 32;
    localparam int DBG_SEL_W    = 5;
    localparam int DBG_CNT_W    = 32;
    localparam int DBG_NUM_REGS = 32;
    localparam int DBG_RST_CYC  = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_RUN     = 3'd2,
        ST_DUMP_RD = 3'd3,
        ST_DUMP_TX = 3'd4,
        ST_DONE    = 3'd5
    } run_state_e;

    typedef logic [1:0] stop_cause_t;

    localparam stop_cause_t STOP_NONE  = 2'd0;
    localparam stop_cause_t STOP_PC    = 2'd1;
    localparam stop_cause_t STOP_LIMIT = 2'd2;
    localparam stop_cause_t STOP_ABORT = 2'd3;

    // A PC match outranks the cycle limit, which outranks an abort.
    function automatic stop_cause_t stop_cause_of(input logic pc_hit,
                                                  input logic lim_hit,
                                                  input logic abort_hit);
        stop_cause_t cause;
        if (pc_hit)         cause = STOP_PC;
        else if (lim_hit)   cause = STOP_LIMIT;
        else if (abort_hit) cause = STOP_ABORT;
        else                cause = STOP_NONE;
        return cause;
    endfunction

endpackage

// File: rtl/sccomp_run_monitor_if.sv
// Register-dump stream from the run monitor to its host: one word per
// valid/ready handshake, tagged with its register index.
interface sccomp_run_monitor_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 5
) ();
    logic              dump_valid;
    logic              dump_ready;
    logic [SEL_W-1:0]  dump_idx;
    logic [DATA_W-1:0] dump_data;

    modport master (
        output dump_valid,
        output dump_idx,
        output dump_data,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_idx,
        input  dump_data,
        output dump_ready
    );
endinterface

// File: rtl/sccomp_run_cycle_counter.sv
// Saturating executed-cycle counter with synchronous clear and a compare
// against a programmable limit (limit 0 never matches).
module sccomp_run_cycle_counter
    import sccomp_dbg_pkg::*;
#(
    parameter int CNT_W = DBG_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             limit_hit
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign limit_hit = (limit != '0) && (count_q == limit);

endmodule

// File: rtl/sccomp_run_monitor.sv
// Run/readback controller: resets and clock-gates the computer, halts on a
// stop PC, cycle limit or abort, then streams the register file to the host.
module sccomp_run_monitor
    import sccomp_dbg_pkg::*;
#(
    parameter int DATA_W     = DBG_DATA_W,
    parameter int ADDR_W     = DBG_ADDR_W,
    parameter int NUM_REGS   = DBG_NUM_REGS,
    parameter int SEL_W      = DBG_SEL_W,
    parameter int CNT_W      = DBG_CNT_W,
    parameter int RST_CYCLES = DBG_RST_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] stop_pc,
    input  logic [CNT_W-1:0]  max_cycles,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              cpu_rstn,
    output logic              cpu_clk_en,
    output logic [SEL_W-1:0]  reg_sel,
    input  logic [DATA_W-1:0] reg_data,
    sccomp_run_monitor_if.master dump,
    output logic              busy,
    output logic              done,
    output logic [1:0]        stop_cause,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_REGS - 1);

    run_state_e        state_q,      state_d;
    logic [RC_W-1:0]   rst_cnt_q,    rst_cnt_d;
    logic [SEL_W-1:0]  idx_q,        idx_d;
    logic [ADDR_W-1:0] stop_pc_q,    stop_pc_d;
    logic [CNT_W-1:0]  max_cycles_q, max_cycles_d;
    stop_cause_t       stop_cause_q, stop_cause_d;
    logic [DATA_W-1:0] dump_data_q,  dump_data_d;
    logic [SEL_W-1:0]  dump_idx_q,   dump_idx_d;

    logic start_ok;
    logic in_run;
    logic pc_hit;
    logic lim_hit;
    logic abort_hit;
    logic hit;
    logic cnt_limit_hit;
    logic dump_valid;

    assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign in_run    = (state_q == ST_RUN);
    assign pc_hit    = in_run && (cpu_pc == stop_pc_q);
    assign lim_hit   = in_run && cnt_limit_hit;
    assign abort_hit = in_run && abort;
    assign hit       = pc_hit || lim_hit || abort_hit;

    sccomp_run_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_counter (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok),
        .en        (cpu_clk_en),
        .limit     (max_cycles_q),
        .count     (cycle_count),
        .limit_hit (cnt_limit_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rst_cnt_q    <= '0;
            idx_q        <= '0;
            stop_pc_q    <= '0;
            max_cycles_q <= '0;
            stop_cause_q <= STOP_NONE;
            dump_data_q  <= '0;
            dump_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            idx_q        <= idx_d;
            stop_pc_q    <= stop_pc_d;
            max_cycles_q <= max_cycles_d;
            stop_cause_q <= stop_cause_d;
            dump_data_q  <= dump_data_d;
            dump_idx_q   <= dump_idx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        idx_d        = idx_q;
        stop_pc_d    = stop_pc_q;
        max_cycles_d = max_cycles_q;
        stop_cause_d = stop_cause_q;
        dump_data_d  = dump_data_q;
        dump_idx_d   = dump_idx_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_RESET;
                    stop_pc_d    = stop_pc;
                    max_cycles_d = max_cycles;
                    stop_cause_d = STOP_NONE;
                    rst_cnt_d    = '0;
                end
            end
            ST_RESET: begin
                if (rst_cnt_q == RC_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            ST_RUN: begin
                if (hit) begin
                    stop_cause_d = stop_cause_of(pc_hit, lim_hit, abort_hit);
                    idx_d        = '0;
                    state_d      = ST_DUMP_RD;
                end
            end
            ST_DUMP_RD: begin
                dump_data_d = reg_data;
                dump_idx_d  = idx_q;
                state_d     = ST_DUMP_TX;
            end
            ST_DUMP_TX: begin
                if (dump.dump_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + SEL_W'(1);
                        state_d = ST_DUMP_RD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The computer stays out of reset from RUN onwards so its state remains
    // observable through the dump and in DONE; only RESET and IDLE hold it.
    always_comb begin
        cpu_rstn   = 1'b0;
        cpu_clk_en = 1'b0;
        reg_sel    = '0;
        dump_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_RESET: begin
                busy = 1'b1;
            end
            ST_RUN: begin
                cpu_rstn   = 1'b1;
                cpu_clk_en = ~hit;
                busy       = 1'b1;
            end
            ST_DUMP_RD: begin
                cpu_rstn = 1'b1;
                reg_sel  = idx_q;
                busy     = 1'b1;
            end
            ST_DUMP_TX: begin
                cpu_rstn   = 1'b1;
                dump_valid = 1'b1;
                busy       = 1'b1;
            end
            ST_DONE: begin
                cpu_rstn = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign dump.dump_valid = dump_valid;
    assign dump.dump_idx   = dump_idx_q;
    assign dump.dump_data  = dump_data_q;
    assign stop_cause      = stop_cause_q;

endmodule

// File: doc/sccomp_run_monitor.md
Name: sccomp_run_monitor

Overview:
- Synthesizable run/readback controller for the single-cycle MIPS computer.
- Sequence per run: drives the CPU reset pulse, gates the CPU clock enable, counts executed cycles, and halts on a programmable stop PC, a cycle limit or an external abort.
- After halting, it scans the register file through the computer's reg_sel/reg_data debug port and streams every register out on a valid/ready interface.
- Sits between the computer and a host (bench, UART or debug bridge).

Parameters:
- DATA_W, 32, register/readback data width
- ADDR_W, 32, PC width
- NUM_REGS, 32, registers scanned (1..32)
- SEL_W, 5, reg_sel width
- CNT_W, 32, cycle counter width
- RST_CYCLES, 4, cycles cpu_rstn held low per run (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  launch run; honoured only in IDLE or DONE
- abort  in  1  request stop during RUN
- stop_pc  in  ADDR_W  PC at which execution halts (sampled at start)
- max_cycles  in  CNT_W  cycle limit, 0 = unlimited (sampled at start)
- cpu_pc  in  ADDR_W  current PC of the computer
- cpu_rstn  out  1  active-low reset to the computer
- cpu_clk_en  out  1  clock enable to the computer
- reg_sel  out  SEL_W  register select to the debug port
- reg_data  in  DATA_W  combinational debug readback
- dump_valid  out  1  dump word valid
- dump_ready  in  1  consumer ready
- dump_idx  out  SEL_W  register index of the dump word
- dump_data  out  DATA_W  register value
- busy  out  1  high in RESET, RUN, DUMP_RD and DUMP_TX
- done  out  1  high in DONE
- stop_cause  out  2  0 none, 1 PC match, 2 cycle limit, 3 abort
- cycle_count  out  CNT_W  cycles executed in the last or current run

Behaviour:
- Reset values: state IDLE; cpu_rstn=0, cpu_clk_en=0, reg_sel=0, dump_valid=0, dump_idx=0, dump_data=0, busy=0, done=0, stop_cause=0, cycle_count=0.
- rst in any state, including mid-run or mid-dump, returns the block to these values on the next edge. A word in flight is dropped.
- FSM: IDLE, RESET, RUN, DUMP_RD, DUMP_TX, DONE.
- IDLE/DONE -> RESET on start:
  - latch stop_pc and max_cycles;
  - clear cycle_count, stop_cause and the reset counter.
- RESET:
  - cpu_rstn=0, cpu_clk_en=0;
  - leave for RUN after exactly RST_CYCLES cycles.
- RUN:
  - cpu_rstn=1.
  - hit = (cpu_pc==stop_pc) | (max_cycles!=0 & cycle_count==max_cycles) | abort.
  - cpu_clk_en = ~hit, combinational, so the instruction at stop_pc is never executed.
  - cycle_count increments on each edge with cpu_clk_en=1 and saturates at all-ones.
  - On hit: stop_cause is set by priority PC match > cycle limit > abort; idx clears; next state DUMP_RD.
- DUMP_RD:
  - reg_sel=idx;
  - on the edge, capture dump_data<=reg_data and dump_idx<=idx;
  - next state DUMP_TX.
- DUMP_TX:
  - dump_valid=1;
  - dump_data and dump_idx stay stable until dump_valid & dump_ready;
  - on handshake: if idx==NUM_REGS-1 go to DONE, else idx++ and go to DUMP_RD.
- Dump cost and order: each register costs at least 2 cycles; registers go out strictly in ascending order 0..NUM_REGS-1, and r0 is included.
- Dump/DONE outputs:
  - cpu_rstn stays 1 and cpu_clk_en stays 0 through the dump and DONE, so the architectural state is frozen and observable.
  - stop_cause and cycle_count hold until the next start.
- cpu_rstn is 0 in IDLE only after rst. A start from DONE re-enters RESET.
- start or abort outside their honoured states is ignored.

Decomposition:
- Shared package sccomp_dbg_pkg holds:
  - the state encoding;
  - stop_cause constants STOP_NONE/STOP_PC/STOP_LIMIT/STOP_ABORT;
  - the default debug widths, shared with the bench and the host bridge.
- One natural sub-module: sccomp_run_cycle_counter, the saturating, enable-gated counter with clear and limit-compare output.

Test Plan:
- Program loop ending at 0x48, stop_pc=0x48, max_cycles=0, start pulse:
  - cpu_rstn low for exactly 4 cycles;
  - stop_cause=1;
  - PC frozen at 0x48;
  - 32 words dumped with idx 0..31 and r0=0;
  - r7 equals the value the program computes;
  - done=1.
- Infinite loop, stop_pc=0xFFFFFFFC, max_cycles=100:
  - cycle_count=100, stop_cause=2, exactly 100 clk_en pulses.
- PC match and cycle limit hit in the same cycle:
  - stop_cause=1.
- abort asserted on cycle 10 of RUN:
  - stop_cause=3, cycle_count=10.
- dump_ready held low 5 cycles, then toggled randomly:
  - dump_data and dump_idx stable while stalled;
  - no index skipped or duplicated.
- rst mid-dump at idx 12:
  - next cycle IDLE with all outputs at reset values;
  - a new start completes a full run.
